// File: rtl/lab1_idiv_pkg.sv
// Shared types and helpers for the lab1 iterative integer divider.
package lab1_idiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_NBITS  = 32;
    localparam int ITER_CNT_W = $clog2(DEF_NBITS + 1);

    // Iteration counter must be able to hold the value NBITS itself.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/lab1_idiv_int_div_iter_if.sv
// Request/response val-rdy streams of the iterative divider.
interface lab1_idiv_int_div_iter_if #(
    parameter int NBITS = 32
) ();

    logic               istream_val;
    logic               istream_rdy;
    logic [2*NBITS-1:0] istream_msg;
    logic               ostream_val;
    logic               ostream_rdy;
    logic [2*NBITS-1:0] ostream_msg;

    modport slave (
        input  istream_val, istream_msg, ostream_rdy,
        output istream_rdy, ostream_val, ostream_msg
    );

    modport master (
        output istream_val, istream_msg, ostream_rdy,
        input  istream_rdy, ostream_val, ostream_msg
    );

endinterface

// File: rtl/lab1_idiv_int_div_dpath.sv
// Divider datapath: operand magnitudes, restoring shift/subtract step, signed result fix-up.
// Optional leading-zero skip is enabled with LAB1_IDIV_SKIP_EN.
module lab1_idiv_int_div_dpath
    import lab1_idiv_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter bit SIGNED = 1'b0,
    parameter int CW     = cnt_width(NBITS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               done_i,
    input  logic [CW-1:0]      cnt_i,
    input  logic [NBITS-1:0]   a_i,
    input  logic [NBITS-1:0]   b_i,
    output logic               last_iter_o,
    output logic [2*NBITS-1:0] res_o
);

    logic [NBITS:0]     rem_q;
    logic [NBITS-1:0]   quo_q, bmag_q, a_q;
    logic               negq_q, negr_q, bzero_q;
    logic [CW-1:0]      iters_q;
    logic [2*NBITS-1:0] res_q;

    logic               a_neg_s, b_neg_s;
    logic [NBITS-1:0]   a_mag_s, b_mag_s, a_init_s;
    logic [CW-1:0]      iters_s;
    logic [NBITS+1:0]   rem_sh_s;
    logic [NBITS:0]     rem_nx_s;
    logic [NBITS-1:0]   quo_nx_s, q_fin_s, r_fin_s;

`ifdef LAB1_IDIV_SKIP_EN
    function automatic logic [CW-1:0] lzc(input logic [NBITS-1:0] v);
        logic [CW-1:0] n;
        logic          hit;
        n   = {CW{1'b0}};
        hit = 1'b0;
        for (int i = NBITS - 1; i >= 0; i--) begin
            hit = hit | v[i];
            if (!hit) n = n + CW'(1);
            else      n = n;
        end
        return n;
    endfunction
`endif

    // Operand magnitudes and iteration count captured at accept
    always_comb begin
        a_neg_s = SIGNED & a_i[NBITS-1];
        b_neg_s = SIGNED & b_i[NBITS-1];
        a_mag_s = a_neg_s ? ({NBITS{1'b0}} - a_i) : a_i;
        b_mag_s = b_neg_s ? ({NBITS{1'b0}} - b_i) : b_i;
`ifdef LAB1_IDIV_SKIP_EN
        if ((a_mag_s == {NBITS{1'b0}}) || (b_i == {NBITS{1'b0}})) begin
            iters_s  = CW'(1);
            a_init_s = a_mag_s;
        end else begin
            iters_s  = CW'(NBITS) - lzc(a_mag_s);
            a_init_s = a_mag_s << lzc(a_mag_s);
        end
`else
        iters_s  = CW'(NBITS);
        a_init_s = a_mag_s;
`endif
    end

    // One restoring step plus sign correction of the would-be final values
    always_comb begin
        rem_sh_s = {rem_q, quo_q[NBITS-1]};
        if (rem_sh_s >= {2'b00, bmag_q}) begin
            rem_nx_s = rem_sh_s[NBITS:0] - {1'b0, bmag_q};
            quo_nx_s = {quo_q[NBITS-2:0], 1'b1};
        end else begin
            rem_nx_s = rem_sh_s[NBITS:0];
            quo_nx_s = {quo_q[NBITS-2:0], 1'b0};
        end
        q_fin_s = negq_q ? ({NBITS{1'b0}} - quo_nx_s) : quo_nx_s;
        r_fin_s = negr_q ? ({NBITS{1'b0}} - rem_nx_s[NBITS-1:0]) : rem_nx_s[NBITS-1:0];
    end

    // Operand and partial remainder/quotient registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_q   <= {(NBITS+1){1'b0}};
            quo_q   <= {NBITS{1'b0}};
            bmag_q  <= {NBITS{1'b0}};
            a_q     <= {NBITS{1'b0}};
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            bzero_q <= 1'b0;
            iters_q <= {CW{1'b0}};
        end else if (load_i) begin
            rem_q   <= {(NBITS+1){1'b0}};
            quo_q   <= a_init_s;
            bmag_q  <= b_mag_s;
            a_q     <= a_i;
            negq_q  <= a_neg_s ^ b_neg_s;
            negr_q  <= a_neg_s;
            bzero_q <= (b_i == {NBITS{1'b0}});
            iters_q <= iters_s;
        end else if (step_i) begin
            rem_q <= rem_nx_s;
            quo_q <= quo_nx_s;
        end
    end

    // Result register; divide-by-zero answer is forced rather than computed
    always_ff @(posedge clk) begin
        if (!reset) begin
            res_q <= {(2*NBITS){1'b0}};
        end else if (done_i) begin
            res_q <= bzero_q ? {{NBITS{1'b1}}, a_q} : {q_fin_s, r_fin_s};
        end
    end

    assign last_iter_o = (cnt_i == (iters_q - CW'(1)));
    assign res_o       = res_q;

endmodule

// File: rtl/lab1_idiv_int_div_iter.sv
// Iterative restoring integer divider (control FSM + iteration counter).
// Define LAB1_IDIV_SKIP_EN to skip the leading-zero iterations of the dividend.
module lab1_idiv_int_div_iter
    import lab1_idiv_pkg::*;
#(
    parameter int NBITS  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic clk,
    input  logic reset,
    lab1_idiv_int_div_iter_if.slave io
);

    localparam int CW = cnt_width(NBITS);

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               load_s, step_s, done_s, last_iter_s, in_rdy_s;
    logic [2*NBITS-1:0] res_s;

    assign in_rdy_s = (state_q == IDLE) & reset;

    // State and iteration counter registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load_s  = 1'b0;
        step_s  = 1'b0;
        done_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.istream_val && in_rdy_s) begin
                    state_d = CALC;
                    cnt_d   = {CW{1'b0}};
                    load_s  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                step_s = 1'b1;
                if (last_iter_s) begin
                    state_d = DONE;
                    cnt_d   = {CW{1'b0}};
                    done_s  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (io.ostream_rdy) state_d = IDLE;
                else                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    lab1_idiv_int_div_dpath #(
        .NBITS  (NBITS),
        .SIGNED (SIGNED),
        .CW     (CW)
    ) u_dpath (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load_s),
        .step_i      (step_s),
        .done_i      (done_s),
        .cnt_i       (cnt_q),
        .a_i         (io.istream_msg[2*NBITS-1:NBITS]),
        .b_i         (io.istream_msg[NBITS-1:0]),
        .last_iter_o (last_iter_s),
        .res_o       (res_s)
    );

    assign io.istream_rdy = in_rdy_s;
    assign io.ostream_val = (state_q == DONE) & reset;
    assign io.ostream_msg = res_s;

endmodule

// File: tb/tb_lab1_idiv_int_div_iter.sv
// Scoreboard bench for the iterative divider: one unsigned and one signed instance,
// randomized operands checked against plain-arithmetic division.
module tb_lab1_idiv_int_div_iter;

    localparam int NB = 32;

    typedef struct {
        logic [63:0] msg;
        int          lat;
        int          k;
    } exp_t;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    int          cyc   = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          bp_en    = 1'b0;
    bit          stall [2];
    logic        in_val  [2];
    logic [63:0] in_msg  [2];
    logic        out_rdy [2];
    logic        in_rdy  [2];
    logic        out_val [2];
    logic [63:0] out_msg [2];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_exp(input int g, input exp_t e);
        if (g == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qsize(input int g);
        return (g == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t pop_exp(input int g);
        if (g == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    // Reference: unsigned or RISC-V signed div/rem, forced answer for b==0
    function automatic logic [63:0] model(input int g, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (g == 0) return {a / b, a % b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return {32'(sa / sb), 32'(sa % sb)};
    endfunction

    function automatic int calc_cycles(input int g, input logic [31:0] a, input logic [31:0] b);
`ifdef LAB1_IDIV_SKIP_EN
        logic [31:0] m;
        int          lead;
        m = (g == 1 && a[31]) ? -a : a;
        if (m == 32'd0 || b == 32'd0) return 1;
        lead = 0;
        while (!m[31]) begin
            m = m << 1;
            lead++;
        end
        return 32 - lead;
`else
        if (g < 0 && a == b) return 0;
        return NB;
`endif
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        lab1_idiv_int_div_iter_if #(.NBITS(NB)) u_if ();
        assign u_if.istream_val = in_val[g];
        assign u_if.istream_msg = in_msg[g];
        assign u_if.ostream_rdy = out_rdy[g];
        assign in_rdy[g]  = u_if.istream_rdy;
        assign out_val[g] = u_if.ostream_val;
        assign out_msg[g] = u_if.ostream_msg;

        lab1_idiv_int_div_iter #(.NBITS(NB), .SIGNED(g == 1)) u_dut (
            .clk   (clk),
            .reset (reset),
            .io    (u_if.slave)
        );

        bit seen;
        int first;
        initial seen = 1'b0;

        always @(negedge clk) begin
            logic r;
            exp_t e;
            if (!reset) begin
                seen = 1'b0;
                out_rdy[g] = 1'b0;
                chk("rst_oval", out_val[g], 64'd0);
            end else begin
                if (stall[g])   r = 1'b0;
                else if (bp_en) r = ($urandom_range(0, 3) != 0);
                else            r = 1'b1;
                out_rdy[g] = r;
                if (out_val[g] === 1'b1) begin
                    if (!seen) begin
                        seen  = 1'b1;
                        first = cyc;
                    end
                    chk("irdy_in_done", in_rdy[g], 64'd0);
                    if (r) begin
                        seen = 1'b0;
                        if (qsize(g) == 0) begin
                            chk("unexpected_resp", out_msg[g], 64'hX);
                        end else begin
                            e = pop_exp(g);
                            chk($sformatf("resp%0d", g), out_msg[g], e.msg);
                            chk($sformatf("latency%0d", g), 64'(first - e.k), 64'(e.lat));
                        end
                    end
                end
            end
        end
    end

    task automatic send(input int g, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        in_val[g] = 1'b1;
        in_msg[g] = {a, b};
        while (in_rdy[g] !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (in_rdy[g] !== 1'b1) begin
            chk("accept_timeout", in_rdy[g], 64'd1);
            in_val[g] = 1'b0;
        end else begin
            e.msg = model(g, a, b);
            e.lat = calc_cycles(g, a, b) + 1;
            e.k   = cyc;
            push_exp(g, e);
            @(posedge clk);
            #1;
            in_val[g] = 1'b0;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(q0.size() + q1.size()), 64'd0);
    endtask

    task automatic rand_run(input int g, input int n);
        logic [31:0] a, b;
        for (int i = 0; i < n; i++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: a = $urandom_range(0, 255);
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = b >> $urandom_range(0, 31);
                default: a = a;
            endcase
            send(g, a, b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        logic [63:0] hold;
        int          t;
        for (int i = 0; i < 2; i++) begin
            in_val[i]  = 1'b0;
            in_msg[i]  = 64'd0;
            out_rdy[i] = 1'b0;
            stall[i]   = 1'b0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_irdy", in_rdy[i], 64'd0);
            chk("rst_oval_main", out_val[i], 64'd0);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_msg", out_msg[i], 64'd0);
            chk("idle_irdy", in_rdy[i], 64'd1);
        end

        // Directed cases
        send(0, 32'd100, 32'd7);
        send(0, 32'h1234_5678, 32'd0);
        send(0, 32'd5, 32'd2);
        send(0, 32'd0, 32'd9);
        send(1, 32'hFFFF_FFF0, 32'd0);
        send(1, 32'hFFFF_FFF9, 32'd2);
        send(1, 32'h8000_0000, 32'hFFFF_FFFF);
        send(1, 32'd5, 32'd2);
        send(1, 32'd0, 32'd9);
        drain();

        // Backpressure in DONE: response held, inputs ignored
        stall[0] = 1'b1;
        send(0, 32'd1000, 32'd3);
        t = 0;
        while (out_val[0] !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("stall_val_seen", out_val[0], 64'd1);
        hold = out_msg[0];
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_val", out_val[0], 64'd1);
            chk("stall_msg", out_msg[0], hold);
            chk("stall_irdy", in_rdy[0], 64'd0);
            in_val[0] = 1'b1;
            in_msg[0] = {$urandom, $urandom};
        end
        #1;
        in_val[0] = 1'b0;
        stall[0]  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_after_rdy", in_rdy[0], 64'd1);
        drain();

        // Reset in the middle of a calculation
        send(0, 32'd123456, 32'd7);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        q0.delete();
        q1.delete();
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("midrst_oval", out_val[i], 64'd0);
            chk("midrst_irdy", in_rdy[i], 64'd0);
        end
        #1 reset = 1'b1;
        send(0, 32'd9, 32'd3);
        drain();

        // Randomized traffic with output backpressure
        bp_en = 1'b1;
        fork
            rand_run(0, 40);
            rand_run(1, 40);
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
